// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with a per-register busy scoreboard for RAW stalls.
// Optional `REGFILE_BYPASS_EN adds write-through bypass from the writeback port to every read port.
module regfile_scoreboard #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD-1:0]      rd_en_i,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    output logic                   stall_o,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [XLEN-1:0]        wr_data_i,
    input  logic                   sb_set_i,
    input  logic [AW-1:0]          sb_set_addr_i,
    input  logic                   flush_i,
    output logic [AW:0]            busy_cnt_o
);

    logic [XLEN-1:0]      regs [REG_COUNT];
    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] busy_next;
    logic [AW:0]          busy_cnt;
    logic [AW:0]          cnt_next;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_next = busy;
        if (wr_en_i) busy_next[wr_addr_i] = 1'b0;
        if (sb_set_i) busy_next[sb_set_addr_i] = 1'b1;
        if (flush_i) busy_next = '0;
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register array is reset here because reads after reset must return 0.
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en_i && wr_addr_i != '0) regs[wr_addr_i] <= wr_data_i;
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    assign busy_cnt_o = busy_cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_k;
        logic            busy_k;

        assign addr = rd_addr_i[k*AW +: AW];

        always_comb begin
            data_k = (addr == '0) ? '0 : regs[addr];
            busy_k = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en_i && wr_addr_i == addr && addr != '0) begin
                data_k = wr_data_i;
                busy_k = sb_set_i && (sb_set_addr_i == addr);
            end
`endif
        end

        assign rd_data_o[k*XLEN +: XLEN] = data_k;
        assign rd_busy_o[k]              = busy_k;
    end

    assign stall_o = |(rd_en_i & rd_busy_o);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard at default parameters.
// Expected same-cycle read values depend on whether REGFILE_BYPASS_EN is defined.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en_i;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic        stall_o;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        sb_set_i;
    logic [4:0]  sb_set_addr_i;
    logic        flush_i;
    logic [5:0]  busy_cnt_o;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .rd_busy_o     (rd_busy_o),
        .stall_o       (stall_o),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .sb_set_i      (sb_set_i),
        .sb_set_addr_i (sb_set_addr_i),
        .flush_i       (flush_i),
        .busy_cnt_o    (busy_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_i = {a1, a0};
        #1;
    endtask

    task automatic idle();
        wr_en_i  = 1'b0;
        sb_set_i = 1'b0;
        flush_i  = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_same;

        rst = 1'b1; rd_en_i = 2'b00; rd_addr_i = '0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        sb_set_i = 1'b0; sb_set_addr_i = '0; flush_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state on both ports for every address
        rd_en_i = 2'b11;
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            check("reset_data", rd_data_o, 64'h0);
            check("reset_busy", {62'h0, rd_busy_o}, 64'h0);
            check("reset_stall", {63'h0, stall_o}, 64'h0);
        end
        check("reset_cnt", {58'h0, busy_cnt_o}, 64'h0);

        // Write x5 and read it on port 1
        wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'hDEADBEEF;
        set_rd(5'd0, 5'd5);
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h0;
`endif
        check("x5_same_cycle", {32'h0, rd_data_o[63:32]}, {32'h0, exp_same});
        tick();
        idle();
        set_rd(5'd5, 5'd5);
        check("x5_both_ports", rd_data_o, {32'hDEADBEEF, 32'hDEADBEEF});

        // Writes to x0 are ignored
        wr_en_i = 1'b1; wr_addr_i = 5'd0; wr_data_i = 32'h1234;
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        check("x0_data", rd_data_o, 64'h0);
        check("x0_busy", {62'h0, rd_busy_o}, 64'h0);

        // Scoreboard set on x7 stalls port 0
        sb_set_i = 1'b1; sb_set_addr_i = 5'd7;
        tick();
        idle();
        rd_en_i = 2'b01;
        set_rd(5'd7, 5'd7);
        check("x7_stall", {63'h0, stall_o}, 64'h1);
        check("x7_busy", {62'h0, rd_busy_o}, 64'h3);
        check("x7_cnt", {58'h0, busy_cnt_o}, 64'h1);
        rd_en_i = 2'b00;
        #1;
        check("x7_no_en_stall", {63'h0, stall_o}, 64'h0);
        rd_en_i = 2'b01;

        // Writeback of x7 clears busy
        wr_en_i = 1'b1; wr_addr_i = 5'd7; wr_data_i = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x7_wb_same_stall", {63'h0, stall_o}, 64'h0);
`else
        check("x7_wb_same_stall", {63'h0, stall_o}, 64'h1);
`endif
        tick();
        idle();
        #1;
        check("x7_wb_stall", {63'h0, stall_o}, 64'h0);
        check("x7_wb_cnt", {58'h0, busy_cnt_o}, 64'h0);
        check("x7_wb_data", {32'h0, rd_data_o[31:0]}, 64'h55);

        // Set and write to the same busy register: set wins
        sb_set_i = 1'b1; sb_set_addr_i = 5'd9;
        tick();
        idle();
        set_rd(5'd9, 5'd9);
        check("x9_cnt_pre", {58'h0, busy_cnt_o}, 64'h1);
        sb_set_i = 1'b1; sb_set_addr_i = 5'd9;
        wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'hA5;
        #1;
        check("x9_same_busy", {62'h0, rd_busy_o}, 64'h3);
        tick();
        idle();
        #1;
        check("x9_busy", {62'h0, rd_busy_o}, 64'h3);
        check("x9_cnt", {58'h0, busy_cnt_o}, 64'h1);
        check("x9_data", {32'h0, rd_data_o[31:0]}, 64'hA5);

        // Re-set of an already busy register does not double count
        sb_set_i = 1'b1; sb_set_addr_i = 5'd9;
        tick();
        idle();
        #1;
        check("x9_reset_cnt", {58'h0, busy_cnt_o}, 64'h1);

        // Write to a non-busy register leaves the scoreboard alone
        wr_en_i = 1'b1; wr_addr_i = 5'd12; wr_data_i = 32'h77;
        tick();
        idle();
        set_rd(5'd12, 5'd9);
        check("x12_data", {32'h0, rd_data_o[31:0]}, 64'h77);
        check("x12_busy", {62'h0, rd_busy_o}, 64'h2);
        check("x12_cnt", {58'h0, busy_cnt_o}, 64'h1);

        // Retire x9, then set x3, x4, x6
        wr_en_i = 1'b1; wr_addr_i = 5'd9; wr_data_i = 32'h99;
        tick();
        idle();
        #1;
        check("x9_retire_cnt", {58'h0, busy_cnt_o}, 64'h0);
        sb_set_i = 1'b1; sb_set_addr_i = 5'd3;
        tick();
        check("set3_cnt", {58'h0, busy_cnt_o}, 64'h1);
        sb_set_addr_i = 5'd4;
        tick();
        check("set4_cnt", {58'h0, busy_cnt_o}, 64'h2);
        sb_set_addr_i = 5'd6;
        tick();
        check("set6_cnt", {58'h0, busy_cnt_o}, 64'h3);

        // Flush with a concurrent set of x8 and write of x3
        sb_set_addr_i = 5'd8; flush_i = 1'b1;
        wr_en_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = 32'h33;
        tick();
        idle();
        set_rd(5'd8, 5'd3);
        check("flush_cnt", {58'h0, busy_cnt_o}, 64'h0);
        check("flush_busy", {62'h0, rd_busy_o}, 64'h0);
        check("flush_wr_data", {32'h0, rd_data_o[63:32]}, 64'h33);
        set_rd(5'd5, 5'd6);
        check("flush_keep_data", {32'h0, rd_data_o[31:0]}, 64'hDEADBEEF);
        check("flush_busy6", {62'h0, rd_busy_o}, 64'h0);

        // Set on x0 is ignored
        sb_set_i = 1'b1; sb_set_addr_i = 5'd0;
        tick();
        idle();
        set_rd(5'd0, 5'd0);
        check("set0_cnt", {58'h0, busy_cnt_o}, 64'h0);
        check("set0_busy", {62'h0, rd_busy_o}, 64'h0);

        // Same-cycle write-through behaviour on x10
        wr_en_i = 1'b1; wr_addr_i = 5'd10; wr_data_i = 32'hCAFEF00D;
        set_rd(5'd10, 5'd0);
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hCAFEF00D;
`else
        exp_same = 32'h0;
`endif
        check("x10_same_cycle", {32'h0, rd_data_o[31:0]}, {32'h0, exp_same});
        tick();
        idle();
        #1;
        check("x10_next_cycle", {32'h0, rd_data_o[31:0]}, 64'hCAFEF00D);

        // Mark every register busy: count saturates at REG_COUNT-1
        sb_set_i = 1'b1;
        for (int i = 1; i < 32; i++) begin
            sb_set_addr_i = 5'(i);
            tick();
        end
        sb_set_addr_i = 5'd0;
        tick();
        idle();
        set_rd(5'd31, 5'd1);
        check("all_busy_cnt", {58'h0, busy_cnt_o}, 64'd31);
        check("all_busy_bits", {62'h0, rd_busy_o}, 64'h3);
        flush_i = 1'b1;
        tick();
        idle();
        #1;
        check("all_flush_cnt", {58'h0, busy_cnt_o}, 64'h0);

        // Reset during activity discards the pending set and write
        sb_set_i = 1'b1; sb_set_addr_i = 5'd11;
        wr_en_i = 1'b1; wr_addr_i = 5'd11; wr_data_i = 32'hBAD;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        set_rd(5'd11, 5'd5);
        check("rst_active_data", rd_data_o, 64'h0);
        check("rst_active_busy", {62'h0, rd_busy_o}, 64'h0);
        check("rst_active_cnt", {58'h0, busy_cnt_o}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RV32I 5-stage pipeline, generalised in width, register count and read-port count.
- Adds a per-register busy scoreboard that tracks pending writes from multi-cycle producers (loads, future mul/div), so the decode stage can stall on RAW hazards that forwarding cannot cover.
- Sits between ID (reads, scoreboard set) and WB (writes, scoreboard clear).

Parameters:
- XLEN, 32, data width of each register.
- REG_COUNT, 32, number of architectural registers; power of two, at least 2; register 0 is hardwired zero.
- NUM_RD, 2, number of independent read ports.
- AW (localparam), $clog2(REG_COUNT), register address width (5 at default).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- rd_en_i  in  NUM_RD  per-port read valid; gates the stall contribution only.
- rd_addr_i  in  NUM_RD*AW  packed read addresses; port k is bits [k*AW +: AW].
- rd_data_o  out  NUM_RD*XLEN  packed read data; combinational.
- rd_busy_o  out  NUM_RD  scoreboard busy bit of each addressed register.
- stall_o  out  1  OR over k of (rd_en_i[k] & rd_busy_o[k]).
- wr_en_i  in  1  writeback enable.
- wr_addr_i  in  AW  writeback destination.
- wr_data_i  in  XLEN  writeback data.
- sb_set_i  in  1  issue of a tracked producer; marks sb_set_addr_i busy.
- sb_set_addr_i  in  AW  producer destination.
- flush_i  in  1  pipeline flush; clears all busy bits.
- busy_cnt_o  out  AW+1  number of registers currently marked busy.

Behaviour:
- Reset: rst is sampled on the clock edge. It zeroes all registers, clears all busy bits and sets busy_cnt_o to 0. After reset, rd_data_o is 0, rd_busy_o is 0 and stall_o is 0.
- Reads are combinational; latency 0. Address 0 always reads 0 with busy 0.
- Write: if wr_en_i is high and wr_addr_i != 0, the register is updated at the clock edge. Writes to address 0 are ignored.
- Busy clear: a write to address A clears busy[A] at the same edge.
- Busy set: sb_set_i with sb_set_addr_i = A != 0 sets busy[A] at the edge. Set with address 0 is ignored.
- Simultaneous set and write to the same address: set wins, busy stays 1 (a new producer supersedes the retiring one). The data is still written.
- Set to an already-busy register: no change; the count is not double-incremented.
- Write to a non-busy register: data is written; busy and count are unchanged.
- flush_i: all busy bits clear next cycle and the count goes to 0. Register data is unaffected. A concurrent sb_set_i is discarded; a concurrent write still updates data. rst has priority over flush_i.
- busy_cnt_o equals the population count of the busy vector, updated by the edge. It ranges 0..REG_COUNT-1 and never wraps.
- All read ports are independent; any number may address the same register.
- rst asserted during activity discards all pending set/write that cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If wr_en_i is high, wr_addr_i == rd_addr_i[k] and the address != 0, then rd_data_o[k] = wr_data_i in the same cycle. rd_busy_o[k] then reads 0, unless sb_set_i targets the same address in that cycle.
- Not defined: reads return the stored value only. The new value is visible the cycle after the write; busy reflects registered state only.

Test Plan:
- Reset then read x0..x31 on both ports -> all rd_data_o = 0, rd_busy_o = 0, busy_cnt_o = 0, stall_o = 0.
- Write x5 = 0xDEADBEEF, next cycle read x5 on port 1 -> 0xDEADBEEF. Write x0 = 0x1234, then read x0 -> 0.
- sb_set x7, rd_en[0] = 1, rd_addr[0] = 7 -> stall_o = 1 and busy_cnt_o = 1. Write x7 = 0x55 -> next cycle stall_o = 0, count 0, data 0x55.
- Same cycle: sb_set x9 and write x9 = 0xA5 with x9 previously busy -> busy[9] stays 1, count unchanged, data 0xA5.
- Set x3, x4 and x6 on successive cycles (count reaches 3), then flush_i together with sb_set x8 -> count 0, all busy 0, x8 not busy.
- With REGFILE_BYPASS_EN: write x10 = 0xCAFEF00D while port 0 reads x10 -> rd_data_o port 0 = 0xCAFEF00D in the same cycle. Without the macro the same cycle shows the old value and the next cycle shows 0xCAFEF00D.
